uart_tx_arbiter: RTL

Round-robin controller sharing one UART transmitter between NUM_REQ byte-stream requesters. It grants the UART to one requester for a whole packet, prefixes each packet with a header byte identifying the source, and forwards the payload bytes over the transmitter's valid/ready handshake. A stall watchdog and a maximum-length limit keep a misbehaving requester from holding the link.

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

    // Arbiter states:
    //   IDLE   | no packet in progress, waiting for any requester
    //   HEADER | presenting the source-id header byte to the UART
    //   FETCH  | waiting for the granted requester to hand over a byte
    //   SEND   | presenting the held payload byte to the UART
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        FETCH  = 2'd2,
        SEND   = 2'd3
    } arb_state_t;

    localparam logic [3:0] HEADER_MAGIC = 4'hA;

    // Cyclic successor of a requester index.
    function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational cyclic-priority select: first requester at or after rr_ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req
);

    logic [IDX_W:0] idx;

    // Walk the ring starting at rr_ptr; the first active request wins.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_req && req_valid[idx[IDX_W-1:0]]) begin
                any_req = 1'b1;
                gnt_idx = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte streams.
// Each packet is prefixed with a header byte {A, source id}; a cumulative
// stall watchdog and a payload length cap bound how long a source holds the link.
//
//   state  | meaning
//   IDLE   | no packet; pick next requester from rr_ptr
//   HEADER | header byte offered to UART
//   FETCH  | req_ready to granted source, waiting for its byte
//   SEND   | held payload byte offered to UART
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int BITS_N   = 8,
    parameter int MAX_LEN  = 16,
    parameter int TIMEOUT  = 50_000,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][BITS_N-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [BITS_N-1:0]              tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [IDX_W-1:0]               grant_id,
    output logic                           busy,
    output logic                           timeout
);

    // Watchdog is a down-counter: loaded with TIMEOUT-1, abort at terminal count zero.
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
    localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_after;
    logic [IDX_W-1:0]  gnt_idx;
    logic              any_req;
    logic [BITS_N-1:0] hold_data;
    logic              hold_last;
    logic [7:0]        byte_cnt;
    logic [7:0]        byte_cnt_inc;
    logic              at_max;
    logic [WD_W-1:0]   wd_rem;
    logic              timeout_q;

    logic grant_load, pkt_start, byte_take, byte_sent, pkt_done, wd_abort;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .gnt_idx   (gnt_idx),
        .any_req   (any_req)
    );

    assign rr_after     = IDX_W'(next_rr(32'(grant_id), unsigned'(NUM_REQ)));
    assign byte_cnt_inc = byte_cnt + 8'd1;
    assign at_max       = (byte_cnt_inc >= LEN_MAX);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt  = state;
        grant_load = 1'b0;
        pkt_start  = 1'b0;
        byte_take  = 1'b0;
        byte_sent  = 1'b0;
        pkt_done   = 1'b0;
        wd_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_load = 1'b1;
                    state_nxt  = HEADER;
                end
            end
            HEADER: begin
                if (tx_ready) begin
                    pkt_start = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                // A byte arriving on the expiry cycle still wins over the abort.
                if (req_valid[grant_id]) begin
                    byte_take = 1'b1;
                    state_nxt = SEND;
                end else if (wd_rem == '0) begin
                    wd_abort  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    byte_sent = 1'b1;
                    if (hold_last || at_max) begin
                        pkt_done  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant register and round-robin pointer; pointer moves past the source when its packet ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            if (grant_load) begin
                grant_id <= gnt_idx;
            end
            if (pkt_done || wd_abort) begin
                rr_ptr <= rr_after;
            end
        end
    end

    // Hold register captures the accepted byte so tx_data stays stable during SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            hold_last <= 1'b0;
        end else if (byte_take) begin
            hold_data <= req_data[grant_id];
            hold_last <= req_last[grant_id];
        end
    end

    // Payload byte counter, saturating at the length cap.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
        end else if (pkt_start) begin
            byte_cnt <= '0;
        end else if (byte_sent && (byte_cnt != LEN_MAX)) begin
            byte_cnt <= byte_cnt_inc;
        end
    end

    // Stall watchdog: counts FETCH cycles without data, accumulated over the whole packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_rem <= WD_LOAD;
        end else if (pkt_start) begin
            wd_rem <= WD_LOAD;
        end else if ((state == FETCH) && !req_valid[grant_id] && (wd_rem != '0)) begin
            wd_rem <= wd_rem - WD_W'(1);
        end
    end

    // Timeout is registered so it is a clean one-cycle pulse after the abort edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_abort;
        end
    end

    // Byte presented to the UART is a pure function of state and registers.
    always_comb begin
        tx_data = '0;
        case (state)
            HEADER:  tx_data = BITS_N'({HEADER_MAGIC, 4'(grant_id)});
            SEND:    tx_data = hold_data;
            default: tx_data = '0;
        endcase
    end

    // One-hot accept strobe to the granted source while fetching.
    always_comb begin
        req_ready = '0;
        if (state == FETCH) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign tx_valid = (state == HEADER) || (state == SEND);
    assign busy     = (state != IDLE);
    assign timeout  = timeout_q;

endmodule
